// File: rtl/hps_cmd_decoder.sv
// rtl/hps_cmd_decoder.sv - HPS PIO command decoder driving image memory and engine
// Optional handshake watchdog enabled by defining CMD_TIMEOUT_EN.
module hps_cmd_decoder #(
  parameter int ADDR_W      = 17,
  parameter int MEM_DEPTH   = 76800,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instruct_in,
  input  logic              enable_in,
  output logic [3:0]        flags_out,
  output logic [7:0]        data_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              alg_start,
  output logic [1:0]        alg_mode,
  input  logic              alg_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_MEM    = 3'd2,
    S_ALGO   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [2:0]      OP_NOP   = 3'd0;
  localparam logic [2:0]      OP_LOAD  = 3'd1;
  localparam logic [2:0]      OP_STORE = 3'd2;
  localparam logic [2:0]      OP_ILL   = 3'd7;
  localparam logic [ADDR_W:0] DEPTH    = (ADDR_W+1)'(MEM_DEPTH);

  state_t              state_q, state_d;
  logic                en_q;
  logic                start;
  logic [2:0]          op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          wdata_q;
  logic                err_q;
  logic                to_q;
  logic                alg_first_q;
  logic [7:0]          data_q;
  logic                is_mem;
  logic                decode_err;
  logic                timeout_hit;
  logic                idle_entry;
  logic                unused_instr;

  assign unused_instr = ^instruct_in[31:28];

  // en_q resets high so an enable held through reset release is not an edge
  assign start      = enable_in & ~en_q;
  assign is_mem     = (op_q == OP_LOAD) || (op_q == OP_STORE);
  assign decode_err = (op_q == OP_ILL) || (is_mem && ({1'b0, addr_q} >= DEPTH));
  assign idle_entry = (state_q != S_IDLE) && (state_d == S_IDLE);

`ifdef CMD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q;

  // DECODE always precedes MEM/ALGO, so clearing there gives a fresh count on entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q == S_DECODE) begin
      cnt_q <= '0;
    end else if (state_q == S_MEM || state_q == S_ALGO) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign timeout_hit = ((state_q == S_MEM && !mem_ack) || (state_q == S_ALGO && !alg_done))
                       && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  localparam int timeout_unused = TIMEOUT_CYC;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_DECODE;
      S_DECODE: begin
        if (decode_err || op_q == OP_NOP) state_d = S_DONE;
        else if (is_mem)                  state_d = S_MEM;
        else                              state_d = S_ALGO;
      end
      S_MEM:    if (mem_ack || timeout_hit)  state_d = S_DONE;
      S_ALGO:   if (alg_done || timeout_hit) state_d = S_DONE;
      S_DONE:   if (!enable_in) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q        <= 1'b1;
      op_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      to_q        <= 1'b0;
      alg_first_q <= 1'b0;
      data_q      <= '0;
    end else begin
      en_q        <= enable_in;
      alg_first_q <= (state_q == S_DECODE) && (state_d == S_ALGO);
      if (state_q == S_IDLE && start) begin
        op_q    <= instruct_in[2:0];
        addr_q  <= instruct_in[ADDR_W+2:3];
        wdata_q <= instruct_in[27:20];
      end
      if (idle_entry) begin
        err_q <= 1'b0;
        to_q  <= 1'b0;
      end else begin
        if (state_q == S_DECODE && decode_err) err_q <= 1'b1;
        if (timeout_hit) begin
          err_q <= 1'b1;
          to_q  <= 1'b1;
        end
      end
      if (state_q == S_MEM && mem_ack && op_q == OP_STORE) data_q <= mem_rdata;
    end
  end

  always_comb begin
    flags_out[0] = (state_q == S_DONE);
    flags_out[1] = err_q;
    flags_out[2] = (state_q == S_DECODE) || (state_q == S_MEM) || (state_q == S_ALGO);
    flags_out[3] = to_q;
    data_out     = data_q;
    mem_req      = (state_q == S_MEM);
    mem_we       = mem_req && (op_q == OP_LOAD);
    mem_addr     = mem_req ? addr_q  : '0;
    mem_wdata    = mem_req ? wdata_q : '0;
    alg_start    = (state_q == S_ALGO) && alg_first_q;
    // opcodes 3..6 map to modes 0..3; the 2-bit wrap does the subtraction
    alg_mode     = (state_q == S_ALGO) ? (op_q[1:0] + 2'd1) : 2'd0;
  end

endmodule

// File: tb/tb_hps_cmd_decoder.sv
// tb/tb_hps_cmd_decoder.sv - bench for hps_cmd_decoder: vector table, random commands, reset and watchdog
module tb_hps_cmd_decoder;

  logic        clk;
  logic        reset;
  logic [31:0] instruct_in;
  logic        enable_in;
  logic [3:0]  flags_out;
  logic [7:0]  data_out;
  logic        mem_req;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        alg_start;
  logic [1:0]  alg_mode;
  logic        alg_done;

  int n_tests = 0;
  int n_fail  = 0;

  hps_cmd_decoder #(.ADDR_W(17), .MEM_DEPTH(76800), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset), .instruct_in(instruct_in), .enable_in(enable_in),
    .flags_out(flags_out), .data_out(data_out), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .alg_start(alg_start), .alg_mode(alg_mode), .alg_done(alg_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    int          lat;
    logic [7:0]  rdata;
    bit          toggle;
    logic [3:0]  exp_flags;
    logic [7:0]  exp_dout;
    int          exp_req;
    int          exp_pulses;
    int          exp_done;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] top, input logic [7:0] wd,
                                     input logic [16:0] a, input logic [2:0] op);
    return {top, wd, a, op};
  endfunction

  // Expected outcome of one command from its opcode, address and response latency
  function automatic void model(input logic [2:0] op, input logic [16:0] a, input int lat,
                                input logic [7:0] rd, inout logic [7:0] dout,
                                output logic [3:0] flags, output int req_n,
                                output int pulses, output int done_idx);
    bit memop;
    memop    = (op == 3'd1) || (op == 3'd2);
    req_n    = 0;
    pulses   = 0;
    done_idx = 1;
    flags    = 4'b0001;
    if (op == 3'd7 || (memop && int'(a) >= 76800)) begin
      flags = 4'b0011;
    end else if (memop) begin
      req_n    = lat + 1;
      done_idx = lat + 2;
      if (op == 3'd2) dout = rd;
    end else if (op != 3'd0) begin
      pulses   = 1;
      done_idx = lat + 2;
    end
  endfunction

  // Issues one command, plays memory/engine, records what the DUT did
  task automatic run_cmd(input logic [31:0] instr, input int lat, input logic [7:0] rdata,
                         input bit toggle, output logic [3:0] flags, output logic [7:0] dout,
                         output int req_n, output int pulses, output int done_idx,
                         output int hold_bad, output logic [3:0] idle_flags);
    logic [2:0] op;
    int since_start;
    op = instr[2:0];
    flags = '0; dout = '0; req_n = 0; pulses = 0; done_idx = -1; hold_bad = 0; since_start = 0;
    instruct_in = instr;
    enable_in = 1'b1;
    for (int idx = 0; idx < 64 && done_idx < 0; idx++) begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      alg_done = 1'b0;
      mem_rdata = 8'($urandom);
      if (toggle) begin
        if (idx == 2) enable_in = 1'b0;
        else if (idx == 3) enable_in = 1'b1;
      end
      if (idx == 0 && flags_out !== 4'b0100) hold_bad++;
      if (flags_out[0]) begin
        done_idx = idx;
        flags = flags_out;
        dout = data_out;
        if (mem_req || alg_start) hold_bad++;
      end else begin
        if (idx > 0 && flags_out !== 4'b0100) hold_bad++;
        if (mem_req) begin
          req_n++;
          if (req_n == 1 && idx != 1) hold_bad++;
          if (mem_we !== (op == 3'd1) || mem_addr !== instr[19:3]) hold_bad++;
          if (op == 3'd1 && mem_wdata !== instr[27:20]) hold_bad++;
          if (req_n == lat + 1) begin
            mem_ack = 1'b1;
            mem_rdata = rdata;
          end
        end
        if (alg_start) begin
          pulses++;
          if (idx != 1) hold_bad++;
        end
        if (pulses > 0) begin
          since_start++;
          if (int'(alg_mode) != int'(op) - 3) hold_bad++;
          if (since_start == lat + 1) alg_done = 1'b1;
        end
      end
    end
    enable_in = 1'b0;
    mem_ack = 1'b0;
    alg_done = 1'b0;
    @(posedge clk); #1;
    idle_flags = flags_out;
  endtask

  logic [3:0] r_flags, r_idle, e_flags;
  logic [7:0] r_dout, m_dout;
  int         r_req, r_pulses, r_done, r_bad, e_req, e_pulses, e_done;
  logic [2:0] r_op;
  logic [16:0] r_a;
  int         r_lat;
  logic [7:0] r_rd, r_wd;
  bit         r_tog;
  int         bad_cnt;

  initial begin
    vecs[0] = '{mk(4'h0, 8'hA5, 17'd5,     3'd1), 3, 8'h00, 1'b0, 4'b0001, 8'h00, 4, 0, 5};
    vecs[1] = '{mk(4'hF, 8'h00, 17'd5,     3'd2), 0, 8'h3C, 1'b0, 4'b0001, 8'h3C, 1, 0, 2};
    vecs[2] = '{mk(4'h0, 8'h12, 17'd9,     3'd0), 0, 8'h00, 1'b0, 4'b0001, 8'h3C, 0, 0, 1};
    vecs[3] = '{mk(4'h0, 8'h00, 17'd5,     3'd7), 0, 8'h00, 1'b0, 4'b0011, 8'h3C, 0, 0, 1};
    vecs[4] = '{mk(4'h0, 8'h55, 17'd76800, 3'd1), 0, 8'h00, 1'b0, 4'b0011, 8'h3C, 0, 0, 1};
    vecs[5] = '{mk(4'h0, 8'h00, 17'd0,     3'd4), 4, 8'h00, 1'b1, 4'b0001, 8'h3C, 0, 1, 6};
    vecs[6] = '{mk(4'hA, 8'h00, 17'd76799, 3'd2), 1, 8'h5A, 1'b0, 4'b0001, 8'h5A, 2, 0, 3};
    vecs[7] = '{mk(4'h0, 8'h00, 17'd3,     3'd3), 0, 8'h00, 1'b0, 4'b0001, 8'h5A, 0, 1, 2};
    vecs[8] = '{mk(4'h0, 8'h00, 17'd76800, 3'd2), 0, 8'hEE, 1'b0, 4'b0011, 8'h5A, 0, 0, 1};
    vecs[9] = '{mk(4'h5, 8'h00, 17'd1,     3'd6), 2, 8'h00, 1'b0, 4'b0001, 8'h5A, 0, 1, 4};

    reset = 1'b1; enable_in = 1'b0; instruct_in = '0;
    mem_ack = 1'b0; mem_rdata = '0; alg_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", int'(flags_out), 0);
    check("reset_data", int'(data_out), 0);
    check("reset_mem_req", int'(mem_req), 0);
    check("reset_alg_start", int'(alg_start), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_cmd(vecs[i].instr, vecs[i].lat, vecs[i].rdata, vecs[i].toggle,
              r_flags, r_dout, r_req, r_pulses, r_done, r_bad, r_idle);
      check($sformatf("vec%0d_flags", i), int'(r_flags), int'(vecs[i].exp_flags));
      check($sformatf("vec%0d_dout", i), int'(r_dout), int'(vecs[i].exp_dout));
      check($sformatf("vec%0d_req_cycles", i), r_req, vecs[i].exp_req);
      check($sformatf("vec%0d_alg_pulses", i), r_pulses, vecs[i].exp_pulses);
      check($sformatf("vec%0d_done_cycle", i), r_done, vecs[i].exp_done);
      check($sformatf("vec%0d_protocol", i), r_bad, 0);
      check($sformatf("vec%0d_idle_flags", i), int'(r_idle), 0);
    end

    m_dout = 8'h5A;
    for (int i = 0; i < 40; i++) begin
      r_op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       r_a = 17'($urandom_range(0, 76799));
        1:       r_a = 17'd76799;
        2:       r_a = 17'd76800;
        default: r_a = 17'($urandom);
      endcase
      r_lat = $urandom_range(0, 5);
      r_rd  = 8'($urandom);
      r_wd  = 8'($urandom);
      model(r_op, r_a, r_lat, r_rd, m_dout, e_flags, e_req, e_pulses, e_done);
      r_tog = (e_req > 0 || e_pulses > 0) && r_lat >= 3;
      run_cmd(mk(4'($urandom), r_wd, r_a, r_op), r_lat, r_rd, r_tog,
              r_flags, r_dout, r_req, r_pulses, r_done, r_bad, r_idle);
      check($sformatf("rnd%0d_flags", i), int'(r_flags), int'(e_flags));
      check($sformatf("rnd%0d_dout", i), int'(r_dout), int'(m_dout));
      check($sformatf("rnd%0d_req_cycles", i), r_req, e_req);
      check($sformatf("rnd%0d_alg_pulses", i), r_pulses, e_pulses);
      check($sformatf("rnd%0d_done_cycle", i), r_done, e_done);
      check($sformatf("rnd%0d_protocol", i), r_bad, 0);
      check($sformatf("rnd%0d_idle_flags", i), int'(r_idle), 0);
    end

    // Reset in the middle of a memory access, enable held high through release
    run_cmd(mk(4'h0, 8'h00, 17'd7, 3'd2), 0, 8'h9E, 1'b0,
            r_flags, r_dout, r_req, r_pulses, r_done, r_bad, r_idle);
    check("pre_reset_dout", int'(r_dout), 8'h9E);
    instruct_in = mk(4'h0, 8'h77, 17'd100, 3'd1);
    enable_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_mem_req", int'(mem_req), 1);
    reset = 1'b1;
    #1;
    check("rst_flags", int'(flags_out), 0);
    check("rst_data", int'(data_out), 0);
    check("rst_mem", int'({mem_req, mem_we, mem_addr, mem_wdata}), 0);
    check("rst_alg", int'({alg_start, alg_mode}), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    bad_cnt = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (mem_req || flags_out != 4'b0000) bad_cnt++;
    end
    check("rst_release_no_cmd", bad_cnt, 0);
    enable_in = 1'b0;
    @(posedge clk); #1;
    run_cmd(mk(4'h0, 8'h00, 17'd9, 3'd2), 2, 8'hC3, 1'b0,
            r_flags, r_dout, r_req, r_pulses, r_done, r_bad, r_idle);
    check("post_rst_flags", int'(r_flags), 4'b0001);
    check("post_rst_dout", int'(r_dout), 8'hC3);
    check("post_rst_done_cycle", r_done, 4);
    check("post_rst_protocol", r_bad, 0);

    // LOAD that never gets an acknowledge
    instruct_in = mk(4'h0, 8'h11, 17'd12, 3'd1);
    enable_in = 1'b1;
    r_req = 0;
`ifdef CMD_TIMEOUT_EN
    r_done = -1;
    r_flags = '0;
    bad_cnt = 1;
    for (int idx = 0; idx < 64 && r_done < 0; idx++) begin
      @(posedge clk); #1;
      if (flags_out[0]) begin
        r_done = idx;
        r_flags = flags_out;
        bad_cnt = int'(mem_req);
      end else if (mem_req) begin
        r_req++;
      end
    end
    check("to_mem_cycles", r_req, 16);
    check("to_flags", int'(r_flags), 4'b1011);
    check("to_mem_req_low", bad_cnt, 0);
    enable_in = 1'b0;
    @(posedge clk); #1;
    check("to_idle_flags", int'(flags_out), 0);
`else
    repeat (40) begin
      @(posedge clk); #1;
      if (mem_req) r_req++;
    end
    check("noto_mem_cycles", r_req, 39);
    check("noto_mem_req_high", int'(mem_req), 1);
    check("noto_flags", int'(flags_out), 4'b0100);
    reset = 1'b1;
    enable_in = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("noto_after_reset", int'(flags_out), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
